// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register file, with a pending-write scoreboard.
// Round-robin grant between EXU (s0) and LSU (s1); one registered write per cycle.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int REG_CNT    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  s0_valid,
    input  logic [ADDR_WIDTH-1:0] s0_rd,
    input  logic [DATA_WIDTH-1:0] s0_wdata,
    input  logic                  s1_valid,
    input  logic [ADDR_WIDTH-1:0] s1_rd,
    input  logic [DATA_WIDTH-1:0] s1_wdata,
    output logic                  s0_ready,
    output logic                  s1_ready,
    output logic                  reg_wen,
    output logic [ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [REG_CNT-1:0]    busy_vec
);

    logic                  last_grant_q, last_grant_d;
    logic                  reg_wen_q, reg_wen_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [REG_CNT-1:0]    busy_q, busy_d;

    logic                  grant0, grant1, accept, set_en;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_wdata;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
        return int'(idx) < REG_CNT;
    endfunction

    // last_grant_q == 0 means s0 was served last, so s1 wins the next conflict
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (s0_valid && s1_valid) begin
                if (last_grant_q) grant0 = 1'b1;
                else              grant1 = 1'b1;
            end else begin
                grant0 = s0_valid;
                grant1 = s1_valid;
            end
        end
    end

    assign s0_ready  = grant0;
    assign s1_ready  = grant1;
    assign accept    = grant0 | grant1;
    assign sel_rd    = grant1 ? s1_rd : s0_rd;
    assign sel_wdata = grant1 ? s1_wdata : s0_wdata;
    assign set_en    = issue_valid && (issue_rd != '0) && in_range(issue_rd);

    always_comb begin
        last_grant_d = accept ? grant1 : last_grant_q;
        reg_wen_d    = accept && (sel_rd != '0) && in_range(sel_rd);
        rd_d         = accept ? sel_rd : rd_q;
        wdata_d      = accept ? sel_wdata : wdata_q;
    end

    // Clear for the committing write first, then set, so a new producer wins a same-index race
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < REG_CNT; i++) begin
            if (reg_wen_q && int'(rd_q) == i) busy_d[i] = 1'b0;
            if (set_en && int'(issue_rd) == i) busy_d[i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b0;
            reg_wen_q    <= 1'b0;
            rd_q         <= '0;
            wdata_q      <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            reg_wen_q    <= reg_wen_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int i = 1; i < REG_CNT; i++) begin
            if (int'(rs1) == i) rs1_busy = busy_q[i];
            if (int'(rs2) == i) rs2_busy = busy_q[i];
        end
    end

    assign reg_wen   = reg_wen_q;
    assign rd        = rd_q;
    assign reg_wdata = wdata_q;
    assign busy_vec  = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expected writes go into a queue that a
// negedge monitor drains whenever reg_wen is seen.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        s0_valid, s1_valid;
    logic [4:0]  s0_rd, s1_rd;
    logic [63:0] s0_wdata, s1_wdata;
    logic        s0_ready, s1_ready;
    logic        reg_wen;
    logic [4:0]  rd;
    logic [63:0] reg_wdata;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic [31:0] busy_vec;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [68:0] exp_q[$];

    regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(64), .REG_CNT(32)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_wdata(s0_wdata),
        .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_wdata(s1_wdata),
        .s0_ready(s0_ready), .s1_ready(s1_ready),
        .reg_wen(reg_wen), .rd(rd), .reg_wdata(reg_wdata),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = '0;
        s0_valid = 1'b0; s0_rd = '0; s0_wdata = '0;
        s1_valid = 1'b0; s1_rd = '0; s1_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic expect_write(input logic [4:0] r, input logic [63:0] d);
        exp_q.push_back({r, d});
    endtask

    // Monitor: every reg_wen pulse must match the oldest expected write
    initial begin
        logic [68:0] e;
        forever begin
            @(negedge clk);
            if (reg_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wen_rd", 64'(rd), 64'h3f);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rd", 64'(rd), 64'(e[68:64]));
                    chk("wb_data", reg_wdata, e[63:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rs1 = '0; rs2 = '0;
        idle_inputs();
        rst = 1'b1;
        step();
        // traffic presented during reset must be ignored
        s0_valid = 1'b1; s0_rd = 5'd4; s0_wdata = 64'hDEAD;
        issue_valid = 1'b1; issue_rd = 5'd4;
        @(negedge clk);
        chk("rst_s0_ready", 64'(s0_ready), 64'd0);
        chk("rst_s1_ready", 64'(s1_ready), 64'd0);
        step();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("rst_wen", 64'(reg_wen), 64'd0);
        chk("rst_busy", 64'(busy_vec), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_wdata", reg_wdata, 64'd0);

        // Single s0 writeback
        step();
        s0_valid = 1'b1; s0_rd = 5'd5; s0_wdata = 64'hAA;
        @(negedge clk);
        chk("single_s0_ready", 64'(s0_ready), 64'd1);
        chk("single_s1_ready", 64'(s1_ready), 64'd0);
        expect_write(5'd5, 64'hAA);
        step();
        idle_inputs();
        @(negedge clk);
        chk("single_wen", 64'(reg_wen), 64'd1);
        step();
        @(negedge clk);
        chk("single_wen_after", 64'(reg_wen), 64'd0);
        chk("hold_rd", 64'(rd), 64'd5);

        // Four-cycle conflict after reset: s1, s0, s1, s0 with no bubbles
        do_reset();
        s0_valid = 1'b1; s0_rd = 5'd1; s0_wdata = 64'h11;
        s1_valid = 1'b1; s1_rd = 5'd2; s1_wdata = 64'h22;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_s1_ready", 64'(s1_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_s0_ready", 64'(s0_ready), (k % 2 == 0) ? 64'd0 : 64'd1);
            if (k > 0) chk("rr_b2b_wen", 64'(reg_wen), 64'd1);
            if (k % 2 == 0) expect_write(5'd2, 64'h22);
            else            expect_write(5'd1, 64'h11);
            step();
        end
        idle_inputs();
        @(negedge clk);
        chk("rr_last_wen", 64'(reg_wen), 64'd1);
        step();

        // Scoreboard set by issue, cleared after the commit cycle
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        idle_inputs();
        rs1 = 5'd7;
        @(negedge clk);
        chk("sb_rs1_busy_set", 64'(rs1_busy), 64'd1);
        chk("sb_vec_7", 64'(busy_vec), 64'h80);
        step();
        s0_valid = 1'b1; s0_rd = 5'd7; s0_wdata = 64'h77;
        @(negedge clk);
        chk("sb_s0_ready", 64'(s0_ready), 64'd1);
        expect_write(5'd7, 64'h77);
        step();
        idle_inputs();
        @(negedge clk);
        chk("sb_busy_during_wen", 64'(rs1_busy), 64'd1);
        step();
        @(negedge clk);
        chk("sb_busy_cleared", 64'(rs1_busy), 64'd0);

        // Commit of rd=3 coincides with a new issue of rd=3
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        idle_inputs();
        s1_valid = 1'b1; s1_rd = 5'd3; s1_wdata = 64'h33;
        expect_write(5'd3, 64'h33);
        step();
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd3;
        @(negedge clk);
        chk("race_wen", 64'(reg_wen), 64'd1);
        step();
        idle_inputs();
        rs2 = 5'd3;
        @(negedge clk);
        chk("race_busy_vec", 64'(busy_vec), 64'h8);
        chk("race_rs2_busy", 64'(rs2_busy), 64'd1);

        // Index 0: accepted, never written, never busy
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd0;
        s1_valid = 1'b1; s1_rd = 5'd0; s1_wdata = 64'h55;
        @(negedge clk);
        chk("r0_s1_ready", 64'(s1_ready), 64'd1);
        step();
        idle_inputs();
        rs1 = 5'd0;
        @(negedge clk);
        chk("r0_wen", 64'(reg_wen), 64'd0);
        chk("r0_busy_vec", 64'(busy_vec), 64'd0);
        chk("r0_rs1_busy", 64'(rs1_busy), 64'd0);

        // Reset right after an accepted write drops busy state and the grant pointer
        step();
        issue_valid = 1'b1; issue_rd = 5'd9;
        s1_valid = 1'b1; s1_rd = 5'd9; s1_wdata = 64'h99;
        @(negedge clk);
        chk("rst_mid_s1_ready", 64'(s1_ready), 64'd1);
        expect_write(5'd9, 64'h99);
        step();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy9", 64'(busy_vec), 64'h200);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_wen", 64'(reg_wen), 64'd0);
        chk("rst_mid_busy", 64'(busy_vec), 64'd0);
        s0_valid = 1'b1; s0_rd = 5'd1; s0_wdata = 64'h11;
        s1_valid = 1'b1; s1_rd = 5'd2; s1_wdata = 64'h22;
        #1;
        chk("rst_mid_grant_s1", 64'(s1_ready), 64'd1);
        chk("rst_mid_grant_s0", 64'(s0_ready), 64'd0);
        expect_write(5'd2, 64'h22);
        step();
        idle_inputs();
        step();
        step();
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, register data width.
REQ-003 SHALL have parameter REG_CNT, default 32, number of architectural registers.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port issue_valid  input  1  an instruction writing issue_rd has issued.
REQ-007 SHALL have port issue_rd  input  ADDR_WIDTH  destination register of the issuing instruction.
REQ-008 SHALL have ports s0_valid / s1_valid  input  1  writeback request from source 0 (EXU) / source 1 (LSU).
REQ-009 SHALL have ports s0_rd / s1_rd  input  ADDR_WIDTH  writeback destination per source.
REQ-010 SHALL have ports s0_wdata / s1_wdata  input  DATA_WIDTH  writeback data per source.
REQ-011 SHALL have ports s0_ready / s1_ready  output  1  request accepted this cycle.
REQ-012 SHALL have port reg_wen  output  1  register file write enable.
REQ-013 SHALL have port rd  output  ADDR_WIDTH  register file write index.
REQ-014 SHALL have port reg_wdata  output  DATA_WIDTH  register file write data.
REQ-015 SHALL have ports rs1 / rs2  input  ADDR_WIDTH  scoreboard query indices.
REQ-016 SHALL have ports rs1_busy / rs2_busy  output  1  queried register has a pending write.
REQ-017 SHALL have port busy_vec  output  REG_CNT  full scoreboard state.

Function
REQ-018 SHALL accept a request when sN_valid && sN_ready on a posedge (handshake); at most one source is granted per cycle.
REQ-019 SHALL compute sN_ready combinationally: a lone valid source is always granted; ready is 0 for a source whose valid is 0.
REQ-020 SHALL, when both sources are valid, grant the source not granted last (round-robin pointer last_grant, 1 bit, reset 0 meaning s0 last, so s1 wins first conflict).
REQ-021 SHALL update last_grant only on an accepted transfer.
REQ-022 SHALL register the accepted rd/wdata and drive reg_wen=1 exactly one cycle after acceptance (latency 1), for one cycle.
REQ-023 SHALL drive reg_wen=0 in any cycle following a cycle with no accepted transfer; rd and reg_wdata hold their last value.
REQ-024 SHALL accept writebacks to index 0 (ready per normal rules) but SHALL NOT assert reg_wen for them.
REQ-025 SHALL set busy_vec[issue_rd] on posedge when issue_valid && issue_rd != 0.
REQ-026 SHALL clear busy_vec[rd] on the posedge ending a reg_wen=1 cycle (write committed).
REQ-027 SHALL, on simultaneous set and clear of the same index, leave the bit set (new producer wins).
REQ-028 SHALL keep busy_vec[0] constantly 0.
REQ-029 SHALL drive rsN_busy = busy_vec[rsN] combinationally; rsN_busy SHALL be 0 when rsN == 0.
REQ-030 SHALL treat indices as modulo REG_CNT only within range; issue_rd or sN_rd >= REG_CNT SHALL be ignored (no busy set, no reg_wen).
REQ-031 SHALL sustain one write per cycle back-to-back with no bubbles when requests are continuous.

Reset
REQ-032 SHALL, with rst=1 at posedge, clear busy_vec to 0, last_grant to 0, reg_wen to 0, rd to 0, reg_wdata to 0.
REQ-033 SHALL drive s0_ready=s1_ready=0 while rst=1 and SHALL discard any transfer or issue presented in that cycle.
REQ-034 SHALL, when rst asserts while a write is pending in the output register, drop it (reg_wen=0 the next cycle).

Verification
REQ-035 SHALL pass: reset, s0_valid=1 rd=5 wdata=0xAA alone -> s0_ready=1 same cycle; next cycle reg_wen=1 rd=5 reg_wdata=0xAA; following cycle reg_wen=0.
REQ-036 SHALL pass: after reset both valid for 4 cycles (s0 rd=1, s1 rd=2) -> grants s1,s0,s1,s0; reg_wen=1 on 4 consecutive cycles with rd 2,1,2,1.
REQ-037 SHALL pass: issue_valid rd=7, then rs1=7 -> rs1_busy=1; writeback rd=7 accepted -> rs1_busy=1 during reg_wen cycle, 0 the cycle after.
REQ-038 SHALL pass: reg_wen cycle committing rd=3 coincides with issue_valid rd=3 -> busy_vec[3]=1 afterward.
REQ-039 SHALL pass: issue rd=0 and s1 writeback rd=0 wdata=0x55 -> s1_ready=1, reg_wen stays 0, busy_vec stays 0.
REQ-040 SHALL pass: accept s0 rd=9 then assert rst next cycle -> reg_wen=0, busy_vec=0, last_grant=0 after reset.
